contour_tracer: RTL and testbench

Parametrised Moore-neighbour boundary tracer for binary sprite masks held one image row per memory word. It raster-scans the mask for the first foreground pixel and walks the outer contour clockwise. Each contour pixel goes out as an (x, y) point on a valid/ready stream with a last flag. It sits between the row-organised display/mask RAM and the edge-position store, and is the generalised successor to the fixed 640-pixel, 3-bit single-shape separation logic.

---
 rtl/contour_tracer.sv | 216 +++++++++++++++++++++
 tb/tb_contour_tracer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/contour_tracer.sv
// Moore-neighbour outer-contour tracer for a row-organised binary mask.
// Raster-scans for the first foreground pixel, then walks the boundary
// clockwise, streaming one (x, y) point per visited contour pixel.
module contour_tracer #(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned BPP        = 3,
  parameter int unsigned MAX_POINTS = 16384,
  localparam int unsigned XW = $clog2(IMG_W),
  localparam int unsigned YW = $clog2(IMG_H),
  localparam int unsigned CW = $clog2(MAX_POINTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 row_rd,
  output logic [YW-1:0]        row_addr,
  input  logic [IMG_W*BPP-1:0] row_data,
  output logic                 pt_valid,
  input  logic                 pt_ready,
  output logic [XW-1:0]        pt_x,
  output logic [YW-1:0]        pt_y,
  output logic                 pt_last,
  output logic                 busy,
  output logic                 done,
  output logic                 empty,
  output logic                 overflow,
  output logic [CW-1:0]        point_count
);

  localparam logic [XW-1:0] XMax   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMax   = YW'(IMG_H - 1);
  localparam logic [CW-1:0] CntMax = CW'(MAX_POINTS);

  typedef enum logic [3:0] {
    StIdle, StScanFetch, StScanCol, StLoadDn, StSearch,
    StEmit, StShiftUp, StShiftDn, StFinish
  } state_e;

  state_e state_q, state_d;

  logic             ph_q;      // fetch phase: 0 = strobe, 1 = capture
  logic [XW-1:0]    x_q, sx_q;
  logic [YW-1:0]    y_q, sy_q;
  logic [2:0]       srch_q;    // direction under test
  logic [2:0]       mv_q;      // last chosen move
  logic [2:0]       tries_q;   // neighbours tested so far in this search
  logic [IMG_W-1:0] up_q, cur_q, dn_q;
  logic [CW-1:0]    cnt_q;

  // Direction -> {n, s, e, w} components, clockwise from E with y growing down.
  function automatic logic [3:0] dir_nsew(input logic [2:0] d);
    case (d)
      3'd0:    dir_nsew = 4'b0010;
      3'd1:    dir_nsew = 4'b0110;
      3'd2:    dir_nsew = 4'b0100;
      3'd3:    dir_nsew = 4'b0101;
      3'd4:    dir_nsew = 4'b0001;
      3'd5:    dir_nsew = 4'b1001;
      3'd6:    dir_nsew = 4'b1000;
      default: dir_nsew = 4'b1010;
    endcase
  endfunction

  logic [3:0]       nb_dir, mv_dir;
  logic [IMG_W-1:0] fg_row, f_row, nb_row;
  logic [XW-1:0]    nb_col;
  logic [YW-1:0]    nb_y, f_addr;
  logic             col_ok, nb_fg, hit_start, cap_hit, is_fetch, f_ok;

  // Reduce each BPP-bit pixel of the incoming word to a foreground bit.
  always_comb begin
    fg_row = '0;
    for (int i = 0; i < IMG_W; i++) fg_row[i] = |row_data[i*BPP +: BPP];
  end

  // Neighbour lookup for the direction under test; off-image columns are background.
  always_comb begin
    nb_dir    = dir_nsew(srch_q);
    mv_dir    = dir_nsew(mv_q);
    nb_col    = nb_dir[1] ? x_q + XW'(1) : (nb_dir[0] ? x_q - XW'(1) : x_q);
    nb_y      = nb_dir[3] ? y_q - YW'(1) : (nb_dir[2] ? y_q + YW'(1) : y_q);
    col_ok    = !(nb_dir[1] && x_q == XMax) && !(nb_dir[0] && x_q == '0);
    nb_row    = nb_dir[3] ? up_q : (nb_dir[2] ? dn_q : cur_q);
    nb_fg     = col_ok && nb_row[nb_col];
    hit_start = (nb_col == sx_q) && (nb_y == sy_q);
    cap_hit   = (cnt_q + CW'(1)) == CntMax;
  end

  // Row fetch addressing; rows -1 and IMG_H are synthesised as zero without a read.
  always_comb begin
    is_fetch = 1'b0;
    f_ok     = 1'b0;
    f_addr   = '0;
    case (state_q)
      StScanFetch: begin
        is_fetch = 1'b1; f_ok = 1'b1; f_addr = y_q;
      end
      StLoadDn, StShiftDn: begin
        is_fetch = 1'b1; f_ok = (y_q != YMax); f_addr = y_q + YW'(1);
      end
      StShiftUp: begin
        is_fetch = 1'b1; f_ok = (y_q != '0); f_addr = y_q - YW'(1);
      end
      default: ;
    endcase
    f_row    = f_ok ? fg_row : '0;
    row_rd   = is_fetch && !ph_q && f_ok;
    row_addr = f_addr;
  end

  // Next-state logic and Moore status outputs.
  always_comb begin
    state_d     = state_q;
    pt_valid    = (state_q == StEmit);
    busy        = (state_q != StIdle) && (state_q != StFinish);
    done        = (state_q == StFinish);
    point_count = cnt_q;
    case (state_q)
      StIdle:      if (start) state_d = StScanFetch;
      StScanFetch: if (ph_q) state_d = StScanCol;
      StScanCol: begin
        if (cur_q[x_q])        state_d = StLoadDn;
        else if (x_q == XMax)  state_d = (y_q == YMax) ? StFinish : StScanFetch;
      end
      StLoadDn:    if (ph_q) state_d = StSearch;
      StSearch:    if (nb_fg || tries_q == 3'd7) state_d = StEmit;
      StEmit: begin
        if (pt_ready) begin
          if (pt_last)        state_d = StFinish;
          else if (mv_dir[2]) state_d = StShiftDn;
          else if (mv_dir[3]) state_d = StShiftUp;
          else                state_d = StSearch;
        end
      end
      StShiftUp, StShiftDn: if (ph_q) state_d = StSearch;
      StFinish:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Datapath: position, row window, search direction and trace status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= 1'b0; x_q <= '0; y_q <= '0; sx_q <= '0; sy_q <= '0;
      srch_q <= '0; mv_q <= '0; tries_q <= '0;
      up_q <= '0; cur_q <= '0; dn_q <= '0; cnt_q <= '0;
      pt_x <= '0; pt_y <= '0; pt_last <= 1'b0; empty <= 1'b0; overflow <= 1'b0;
    end else begin
      ph_q <= is_fetch && !ph_q;
      case (state_q)
        StIdle: if (start) begin
          empty <= 1'b0; overflow <= 1'b0; cnt_q <= '0;
          up_q <= '0; cur_q <= '0; dn_q <= '0; x_q <= '0; y_q <= '0;
        end
        StScanFetch: if (ph_q) begin
          up_q  <= cur_q;
          cur_q <= f_row;
        end
        StScanCol: begin
          if (cur_q[x_q]) begin
            sx_q <= x_q; sy_q <= y_q;
          end else if (x_q == XMax) begin
            x_q <= '0;
            if (y_q == YMax) empty <= 1'b1;
            else             y_q <= y_q + YW'(1);
          end else begin
            x_q <= x_q + XW'(1);
          end
        end
        StLoadDn: if (ph_q) begin
          dn_q    <= f_row;
          srch_q  <= 3'd6;   // first search starts at N
          tries_q <= '0;
        end
        StSearch: begin
          if (nb_fg || tries_q == 3'd7) begin
            pt_x     <= x_q;
            pt_y     <= y_q;
            mv_q     <= srch_q;
            pt_last  <= !nb_fg || hit_start || cap_hit;
            overflow <= cap_hit;
          end else begin
            srch_q  <= srch_q + 3'd1;
            tries_q <= tries_q + 3'd1;
          end
        end
        StEmit: if (pt_ready) begin
          cnt_q <= cnt_q + CW'(1);
          if (!pt_last) begin
            if (mv_dir[1]) x_q <= x_q + XW'(1);
            if (mv_dir[0]) x_q <= x_q - XW'(1);
            if (mv_dir[2]) begin
              y_q <= y_q + YW'(1); up_q <= cur_q; cur_q <= dn_q;
            end
            if (mv_dir[3]) begin
              y_q <= y_q - YW'(1); dn_q <= cur_q; cur_q <= up_q;
            end
            srch_q  <= mv_q[0] ? mv_q + 3'd5 : mv_q + 3'd6;
            tries_q <= '0;
          end
        end
        StShiftUp: if (ph_q) up_q <= f_row;
        StShiftDn: if (ph_q) dn_q <= f_row;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_contour_tracer.sv
// Directed bench: block, line, single pixel, empty frame, stall, cap and mid-trace reset.
module tb_contour_tracer;

  localparam int W = 32;
  localparam int H = 32;
  localparam int B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pt_ready = 1'b1;

  logic [W*B-1:0] mem [H];

  // Instance a: default point cap; instance b: cap of 4.
  logic         row_rd_a, pt_valid_a, pt_last_a, busy_a, done_a, empty_a, overflow_a;
  logic [4:0]   row_addr_a, pt_y_a;
  logic [4:0]   pt_x_a;
  logic [14:0]  count_a;
  logic [W*B-1:0] row_data_a;
  logic         row_rd_b, pt_valid_b, pt_last_b, busy_b, done_b, empty_b, overflow_b;
  logic [4:0]   row_addr_b, pt_y_b;
  logic [4:0]   pt_x_b;
  logic [2:0]   count_b;
  logic [W*B-1:0] row_data_b;

  contour_tracer #(.IMG_W(W), .IMG_H(H), .BPP(B), .MAX_POINTS(16384)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .row_rd(row_rd_a), .row_addr(row_addr_a), .row_data(row_data_a),
    .pt_valid(pt_valid_a), .pt_ready(pt_ready), .pt_x(pt_x_a), .pt_y(pt_y_a),
    .pt_last(pt_last_a), .busy(busy_a), .done(done_a), .empty(empty_a),
    .overflow(overflow_a), .point_count(count_a)
  );

  contour_tracer #(.IMG_W(W), .IMG_H(H), .BPP(B), .MAX_POINTS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .row_rd(row_rd_b), .row_addr(row_addr_b), .row_data(row_data_b),
    .pt_valid(pt_valid_b), .pt_ready(pt_ready), .pt_x(pt_x_b), .pt_y(pt_y_b),
    .pt_last(pt_last_b), .busy(busy_b), .done(done_b), .empty(empty_b),
    .overflow(overflow_b), .point_count(count_b)
  );

  always #5 clk = ~clk;

  int rd_cnt = 0;
  always @(posedge clk) begin
    if (row_rd_a) begin
      row_data_a <= mem[row_addr_a];
      rd_cnt <= rd_cnt + 1;
    end
    if (row_rd_b) row_data_b <= mem[row_addr_b];
  end

  int errors = 0;
  int checks = 0;

  int px_a [32], py_a [32], pl_a [32], px_b [32], py_b [32], pl_b [32];
  int na, nb, done_a_cyc, done_b_cyc, first_a, last_acc_a, stall_bad, timed_out;

  int exp_x [8] = '{10, 11, 12, 12, 12, 11, 10, 10};
  int exp_y [8] = '{20, 20, 20, 21, 22, 22, 22, 21};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int r = 0; r < H; r++) mem[r] = '0;
  endtask

  task automatic set_px(input int x, input int y, input logic [2:0] v);
    mem[y][x*B +: B] = v;
  endtask

  // Pulse start, then run both streams; stall_len cycles of ready low on point stall_idx
  // (expected held at ex, ey). Returns early once stop_at points of instance a are taken.
  task automatic run_trace(input int stall_idx, input int stall_len, input int ex,
                           input int ey, input int stop_at);
    int stall = 0;
    na = 0; nb = 0; done_a_cyc = -1; done_b_cyc = -1; first_a = -1; last_acc_a = -1;
    stall_bad = 0; timed_out = 1;
    for (int i = 0; i < 32; i++) begin
      px_a[i] = -1; py_a[i] = -1; pl_a[i] = -1; px_b[i] = -1; py_b[i] = -1; pl_b[i] = -1;
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      pt_ready = 1'b1;
      if (pt_valid_a && first_a < 0) first_a = cyc;
      if (pt_valid_a && na == stall_idx && stall < stall_len) begin
        pt_ready = 1'b0;
        stall++;
        if (int'(pt_x_a) != ex || int'(pt_y_a) != ey) stall_bad++;
      end
      if (pt_valid_a && pt_ready && na < 32) begin
        px_a[na] = int'(pt_x_a); py_a[na] = int'(pt_y_a); pl_a[na] = int'(pt_last_a);
        if (pt_last_a) last_acc_a = cyc;
        na++;
      end
      if (pt_valid_b && pt_ready && nb < 32) begin
        px_b[nb] = int'(pt_x_b); py_b[nb] = int'(pt_y_b); pl_b[nb] = int'(pt_last_b);
        nb++;
      end
      if (done_a && done_a_cyc < 0) done_a_cyc = cyc;
      if (done_b && done_b_cyc < 0) done_b_cyc = cyc;
      if (stop_at > 0 && na == stop_at) begin
        timed_out = 0;
        return;
      end
      if (done_a_cyc >= 0 && done_b_cyc >= 0) begin
        timed_out = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic load_block();
    clear_mem();
    for (int y = 20; y <= 22; y++)
      for (int x = 10; x <= 12; x++) set_px(x, y, 3'(1 << ((x + y) % 3)));
  endtask

  task automatic check_block_stream(input string tag);
    chk({tag, " timeout"}, timed_out, 0);
    chk({tag, " npts"}, na, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s x%0d", tag, i), px_a[i], exp_x[i]);
      chk($sformatf("%s y%0d", tag, i), py_a[i], exp_y[i]);
      chk($sformatf("%s last%0d", tag, i), pl_a[i], (i == 7) ? 1 : 0);
    end
    chk({tag, " count"}, count_a, 8);
    chk({tag, " overflow"}, overflow_a, 0);
    chk({tag, " empty"}, empty_a, 0);
    chk({tag, " done timing"}, done_a_cyc, last_acc_a + 1);
  endtask

  initial begin
    clear_mem();
    #1;
    chk("reset pt_valid", pt_valid_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset row_rd", row_rd_a, 0);
    chk("reset pt_xy", {pt_x_a, pt_y_a}, 0);
    chk("reset count", count_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Solid 3x3 block; instance b checks the point cap.
    load_block();
    run_trace(-1, 0, 0, 0, 0);
    check_block_stream("block");
    chk("cap npts", nb, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cap x%0d", i), px_b[i], exp_x[i]);
      chk($sformatf("cap y%0d", i), py_b[i], exp_y[i]);
      chk($sformatf("cap last%0d", i), pl_b[i], (i == 3) ? 1 : 0);
    end
    chk("cap overflow", overflow_b, 1);
    chk("cap count", count_b, 4);
    chk("busy after", busy_a, 0);

    // Block again with ready held low for 20 cycles on the second point.
    run_trace(1, 20, 11, 20, 0);
    check_block_stream("stall");
    chk("stall held", stall_bad, 0);

    // Horizontal line.
    clear_mem();
    set_px(5, 5, 3'b100); set_px(6, 5, 3'b010); set_px(7, 5, 3'b001);
    run_trace(-1, 0, 0, 0, 0);
    chk("line npts", na, 4);
    chk("line p0", {px_a[0][7:0], py_a[0][7:0], pl_a[0][7:0]}, {8'd5, 8'd5, 8'd0});
    chk("line p1", {px_a[1][7:0], py_a[1][7:0], pl_a[1][7:0]}, {8'd6, 8'd5, 8'd0});
    chk("line p2", {px_a[2][7:0], py_a[2][7:0], pl_a[2][7:0]}, {8'd7, 8'd5, 8'd0});
    chk("line p3", {px_a[3][7:0], py_a[3][7:0], pl_a[3][7:0]}, {8'd6, 8'd5, 8'd1});
    chk("line count", count_a, 4);

    // Single pixel at the origin: rows 0 and 1 read, nothing else.
    clear_mem();
    set_px(0, 0, 3'b010);
    rd_cnt = 0;
    run_trace(-1, 0, 0, 0, 0);
    chk("pix npts", na, 1);
    chk("pix point", {px_a[0][7:0], py_a[0][7:0], pl_a[0][7:0]}, {8'd0, 8'd0, 8'd1});
    chk("pix count", count_a, 1);
    chk("pix reads", rd_cnt, 2);
    chk("pix first latency", first_a, 14);
    chk("pix overflow", overflow_a, 0);

    // Empty frame.
    clear_mem();
    run_trace(-1, 0, 0, 0, 0);
    chk("empty npts", na, 0);
    chk("empty flag", empty_a, 1);
    chk("empty count", count_a, 0);
    chk("empty done cycle", done_a_cyc, H * (W + 2) + 1);

    // Reset during the search for the fifth point, then a clean re-run.
    load_block();
    run_trace(-1, 0, 0, 0, 4);
    chk("abort reached", timed_out, 0);
    repeat (3) @(negedge clk);
    chk("abort in search", {pt_valid_a, busy_a}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("async pt_valid", pt_valid_a, 0);
    chk("async busy", busy_a, 0);
    chk("async row_rd", row_rd_a, 0);
    chk("async count", count_a, 0);
    chk("async flags", {done_a, empty_a, overflow_a, pt_last_a}, 0);
    chk("async pt_xy", {pt_x_a, pt_y_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_trace(-1, 0, 0, 0, 0);
    check_block_stream("rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
